iter_color_mapper: RTL and testbench
====================================

Name: iter_color_mapper

Overview:
- Pipelined stage that converts per-pixel Mandelbrot escape-iteration counts into 24-bit RGB.
- Sits directly upstream of the AXI-Stream pixel packer. Its output handshake (valid/sof/eol/r/g/b, ready) connects straight to the packer's pixel input.
- Supports per-frame palette rotation, so successive frames cycle colour.

Parameters:
- ITER_W, 16, width of the iteration-count input.
- MAX_ITER, 255, iteration limit; any count >= MAX_ITER is an interior point and maps to black.
- ROT_STEP, 4, palette offset increment applied at each accepted start-of-frame when rotation is enabled.

Ports:
- aclk  input  1  clock; all logic on rising edge.
- areset  input  1  synchronous reset, active-high.
- iter  input  ITER_W  escape-iteration count for the current pixel.
- iter_valid  input  1  input beat valid.
- iter_sof  input  1  input pixel is first of frame.
- iter_eol  input  1  input pixel is last of line.
- iter_ready  output  1  mapper can accept an input beat this cycle.
- rot_en  input  1  enable palette rotation; sampled on the sof beat.
- r  output  8  red, to packer.
- g  output  8  green, to packer.
- b  output  8  blue, to packer.
- valid  output  1  output pixel valid, to packer.
- sof  output  1  output pixel is start of frame.
- eol  output  1  output pixel is end of line.
- ready  input  1  packer ready to accept.
- frame_offset  output  8  current palette offset (debug/status).

Behaviour:
- Clock, reset and pipeline control:
  - Reset: one clock (aclk); reset is synchronous and active-high (areset). While areset=1 at a rising edge, the following are cleared to 0: both stage valid bits, valid, sof, eol, r, g, b, frame_offset.
  - Global advance enable: en = !valid || ready. Combinational.
  - iter_ready = en. Combinational, with no registered dependency other than valid. After reset, iter_ready=1.
  - Input fire = iter_valid && iter_ready. Output fire = valid && ready.
- Stage 1 (registered when en):
  - s1_valid <= iter_valid. Flags sof/eol are captured.
  - interior <= (iter >= MAX_ITER).
  - idx <= (iter[7:0] + off_eff) mod 256, where off_eff = (iter_sof && rot_en) ? frame_offset + ROT_STEP : frame_offset.
- Stage 2 / outputs (registered when en):
  - valid <= s1_valid; sof/eol copied from stage 1.
  - If interior: r=g=b=8'h00.
  - Else: r = idx; g = {idx[6:0],1'b0}; b = ~idx.
- Latency: exactly 2 cycles from input fire to valid, with ready held high. Throughput is 1 pixel/clock when ready=1.
- Backpressure: when valid=1 && ready=0, en=0. Both stages hold every register unchanged, and r/g/b/sof/eol stay stable until output fire. No beat is dropped or duplicated.
- Bubbles: when en=1 and iter_valid=0, a bubble enters stage 1. Data registers in a non-valid stage are don't-care, but valid must be 0.
- Palette rotation:
  - On input fire with iter_sof=1 and rot_en=1: frame_offset <= frame_offset + ROT_STEP, mod 256, wrapping 8'hFC+4 -> 8'h00.
  - The sof pixel itself uses the new offset. All later pixels of that frame use it too.
  - Otherwise frame_offset holds.
- iter width rule: only iter[7:0] feeds idx. The interior compare uses the full ITER_W width.
- Simultaneous sof and eol on one beat (1-pixel line at frame start): both flags are propagated unchanged.
- Reset mid-stream: in-flight beats are discarded, with no partial output after reset deasserts. The packer must be reset in the same cycle.

Test Plan:
- Reset then a single beat iter=10, rot_en=0, ready=1 -> valid rises exactly 2 cycles after input fire with r=0x0A, g=0x14, b=0xF5.
- iter=255 and iter=1000 (MAX_ITER=255) -> both output r=g=b=0x00.
- Stream of 8 beats with ready toggling 1,0,0,1,… -> output sequence equals input order exactly; r/g/b/sof/eol constant across every ready=0 cycle; iter_ready=0 whenever valid=1 && ready=0.
- Frame rotation, rot_en=1: sof beats with iter=0 -> frame_offset 4, 8, …; the sof pixel of frame 1 gives r=0x04; after 64 frames frame_offset wraps to 0x00.
- Beat with sof=1 and eol=1 plus rot_en=0 -> both flags set on output; frame_offset unchanged.
- Assert areset with 2 beats in flight -> next cycle valid=0, frame_offset=0, and no stale beat appears afterwards.

Source files
------------

// File: rtl/iter_color_mapper.sv
// iter_color_mapper: two-stage pipeline that maps Mandelbrot escape counts to
// 24-bit RGB. The palette offset can rotate by a fixed step on each frame.
module iter_color_mapper #(
    parameter int unsigned ITER_W   = 16,
    parameter int unsigned MAX_ITER = 255,
    parameter int unsigned ROT_STEP = 4
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [ITER_W-1:0] iter,
    input  logic              iter_valid,
    input  logic              iter_sof,
    input  logic              iter_eol,
    output logic              iter_ready,
    input  logic              rot_en,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              valid,
    output logic              sof,
    output logic              eol,
    input  logic              ready,
    output logic [7:0]        frame_offset
);

    localparam int unsigned COLOR_W = 8;

    // Stage 1 registers
    logic               r_s1_valid;
    logic               r_s1_sof;
    logic               r_s1_eol;
    logic               r_s1_interior;
    logic [COLOR_W-1:0] r_s1_idx;

    // Combinational pipeline control and stage-1 datapath
    logic               w_en;
    logic               w_fire_in;
    logic               w_rot_req;
    logic [COLOR_W-1:0] w_off_next;
    logic [COLOR_W-1:0] w_off_eff;
    logic [COLOR_W-1:0] w_idx;
    logic               w_interior;

    // The whole pipe advances unless the output is held by the packer
    assign w_en       = !valid || ready;
    assign iter_ready = w_en;
    assign w_fire_in  = iter_valid && w_en;

    // The sof beat that triggers a rotation already uses the new offset
    assign w_rot_req  = iter_sof && rot_en;
    assign w_off_next = frame_offset + COLOR_W'(ROT_STEP);
    assign w_off_eff  = w_rot_req ? w_off_next : frame_offset;
    assign w_idx      = iter[COLOR_W-1:0] + w_off_eff;
    assign w_interior = (iter >= ITER_W'(MAX_ITER));

    // Palette offset: advances only on an accepted sof beat with rotation on
    always_ff @(posedge aclk) begin
        if (areset) begin
            frame_offset <= '0;
        end else if (w_fire_in && w_rot_req) begin
            frame_offset <= w_off_next;
        end
    end

    // Stage 1: capture flags, interior decision and palette index
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_s1_valid    <= 1'b0;
            r_s1_sof      <= 1'b0;
            r_s1_eol      <= 1'b0;
            r_s1_interior <= 1'b0;
            r_s1_idx      <= '0;
        end else if (w_en) begin
            r_s1_valid    <= iter_valid;
            r_s1_sof      <= iter_sof;
            r_s1_eol      <= iter_eol;
            r_s1_interior <= w_interior;
            r_s1_idx      <= w_idx;
        end
    end

    // Stage 2: palette lookup into registered outputs; interior points are black
    always_ff @(posedge aclk) begin
        if (areset) begin
            valid <= 1'b0;
            sof   <= 1'b0;
            eol   <= 1'b0;
            r     <= '0;
            g     <= '0;
            b     <= '0;
        end else if (w_en) begin
            valid <= r_s1_valid;
            sof   <= r_s1_sof;
            eol   <= r_s1_eol;
            if (r_s1_interior) begin
                r <= '0;
                g <= '0;
                b <= '0;
            end else begin
                r <= r_s1_idx;
                g <= {r_s1_idx[COLOR_W-2:0], 1'b0};
                b <= ~r_s1_idx;
            end
        end
    end

endmodule

// File: tb/tb_iter_color_mapper.sv
// Directed self-checking bench for iter_color_mapper.
`timescale 1ns/1ps
module tb_iter_color_mapper;

    localparam int unsigned ITER_W = 16;
    localparam int unsigned NBEAT  = 8;

    logic              aclk;
    logic              areset;
    logic [ITER_W-1:0] iter;
    logic              iter_valid;
    logic              iter_sof;
    logic              iter_eol;
    logic              iter_ready;
    logic              rot_en;
    logic [7:0]        r;
    logic [7:0]        g;
    logic [7:0]        b;
    logic              valid;
    logic              sof;
    logic              eol;
    logic              ready;
    logic [7:0]        frame_offset;

    int n_checks = 0;
    int n_pass   = 0;

    // Beat table used by run_stream
    logic [ITER_W-1:0] v_iter [NBEAT];
    logic              v_sof  [NBEAT];
    logic              v_eol  [NBEAT];
    logic              v_rot  [NBEAT];
    logic [23:0]       v_exp  [NBEAT];

    iter_color_mapper #(
        .ITER_W  (16),
        .MAX_ITER(255),
        .ROT_STEP(4)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .iter        (iter),
        .iter_valid  (iter_valid),
        .iter_sof    (iter_sof),
        .iter_eol    (iter_eol),
        .iter_ready  (iter_ready),
        .rot_en      (rot_en),
        .r           (r),
        .g           (g),
        .b           (b),
        .valid       (valid),
        .sof         (sof),
        .eol         (eol),
        .ready       (ready),
        .frame_offset(frame_offset)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_beat(input int i, input logic [ITER_W-1:0] it, input logic s,
                            input logic e, input logic ro, input logic [23:0] ex);
        v_iter[i] = it;
        v_sof[i]  = s;
        v_eol[i]  = e;
        v_rot[i]  = ro;
        v_exp[i]  = ex;
    endtask

    // Push n beats from the table under a repeating 4-cycle ready pattern and
    // score outputs in order, checking hold stability under backpressure.
    task automatic run_stream(input int n, input logic [3:0] rdy_pat);
        int          in_i  = 0;
        int          out_i = 0;
        int          cyc   = 0;
        logic        hold  = 1'b0;
        logic [23:0] h_rgb = '0;
        logic [1:0]  h_flg = '0;
        while (out_i < n && cyc < 200) begin
            ready = rdy_pat[cyc % 4];
            if (in_i < n) begin
                iter       = v_iter[in_i];
                iter_sof   = v_sof[in_i];
                iter_eol   = v_eol[in_i];
                rot_en     = v_rot[in_i];
                iter_valid = 1'b1;
            end else begin
                iter_valid = 1'b0;
                iter_sof   = 1'b0;
                iter_eol   = 1'b0;
                rot_en     = 1'b0;
            end
            #1;
            if (hold) begin
                check("hold_rgb", 32'({r, g, b}), 32'(h_rgb));
                check("hold_flags", 32'({valid, sof, eol}), 32'({1'b1, h_flg}));
            end
            hold = 1'b0;
            if (valid && !ready) begin
                check("bp_iter_ready", 32'(iter_ready), 32'd0);
                hold  = 1'b1;
                h_rgb = {r, g, b};
                h_flg = {sof, eol};
            end
            if (valid && ready) begin
                check("out_rgb", 32'({r, g, b}), 32'(v_exp[out_i]));
                check("out_flags", 32'({sof, eol}), 32'({v_sof[out_i], v_eol[out_i]}));
                out_i++;
            end
            if (iter_valid && iter_ready) in_i++;
            tick();
            cyc++;
        end
        if (out_i < n) check("stream_timeout", 32'(out_i), 32'(n));
        iter_valid = 1'b0;
        iter_sof   = 1'b0;
        iter_eol   = 1'b0;
        rot_en     = 1'b0;
        ready      = 1'b1;
        #1;
        check("no_extra_beat", 32'(valid), 32'd0);
    endtask

    initial begin
        logic [7:0] off;
        areset     = 1'b1;
        iter       = '0;
        iter_valid = 1'b0;
        iter_sof   = 1'b0;
        iter_eol   = 1'b0;
        rot_en     = 1'b0;
        ready      = 1'b1;

        // Reset state
        tick();
        tick();
        areset = 1'b0;
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_rgb", 32'({r, g, b}), 32'd0);
        check("rst_flags", 32'({sof, eol}), 32'd0);
        check("rst_offset", 32'(frame_offset), 32'd0);
        check("rst_iter_ready", 32'(iter_ready), 32'd1);

        // Single beat latency: iter=10 -> 0A 14 F5 two cycles after fire
        iter       = 16'd10;
        iter_valid = 1'b1;
        tick();
        iter_valid = 1'b0;
        check("lat_cycle1", 32'(valid), 32'd0);
        tick();
        check("lat_cycle2", 32'(valid), 32'd1);
        check("lat_rgb", 32'({r, g, b}), 32'h0A14F5);
        tick();
        check("lat_after", 32'(valid), 32'd0);

        // Eight beats, ready 1,0,0,1 repeating; includes interior points 255 and 1000
        set_beat(0, 16'd0,    1'b1, 1'b0, 1'b0, 24'h0000FF);
        set_beat(1, 16'd1,    1'b0, 1'b0, 1'b0, 24'h0102FE);
        set_beat(2, 16'h007F, 1'b0, 1'b0, 1'b0, 24'h7FFE80);
        set_beat(3, 16'h0080, 1'b0, 1'b0, 1'b0, 24'h80007F);
        set_beat(4, 16'h00FE, 1'b0, 1'b0, 1'b0, 24'hFEFC01);
        set_beat(5, 16'd255,  1'b0, 1'b0, 1'b0, 24'h000000);
        set_beat(6, 16'd1000, 1'b0, 1'b0, 1'b0, 24'h000000);
        set_beat(7, 16'h0055, 1'b0, 1'b1, 1'b0, 24'h55AAAA);
        run_stream(8, 4'b1001);

        // sof and eol on one beat, rotation off
        set_beat(0, 16'd3, 1'b1, 1'b1, 1'b0, 24'h0306FC);
        run_stream(1, 4'b1111);
        check("sofeol_offset", 32'(frame_offset), 32'd0);

        // Rotation: frame 1 -> offset 4
        set_beat(0, 16'd0, 1'b1, 1'b0, 1'b1, 24'h0408FB);
        set_beat(1, 16'd2, 1'b0, 1'b1, 1'b1, 24'h060CF9);
        run_stream(2, 4'b1111);
        check("rot_offset_f1", 32'(frame_offset), 32'd4);

        // Frame 2 -> offset 8; second pixel 249+8 wraps to index 1
        set_beat(0, 16'd0,   1'b1, 1'b0, 1'b1, 24'h0810F7);
        set_beat(1, 16'd249, 1'b0, 1'b1, 1'b0, 24'h0102FE);
        run_stream(2, 4'b1111);
        check("rot_offset_f2", 32'(frame_offset), 32'd8);

        // Frames 3..63
        for (int k = 3; k < 64; k++) begin
            off = 8'(4 * k);
            set_beat(0, 16'd0, 1'b1, 1'b1, 1'b1, {off, off[6:0], 1'b0, ~off});
            run_stream(1, 4'b1111);
        end
        check("rot_offset_f63", 32'(frame_offset), 32'h0FC);

        // Frame 64 wraps offset to 0
        set_beat(0, 16'd0, 1'b1, 1'b1, 1'b1, 24'h0000FF);
        run_stream(1, 4'b1111);
        check("rot_offset_wrap", 32'(frame_offset), 32'd0);

        // Reset with two beats in flight
        iter       = 16'd5;
        iter_sof   = 1'b1;
        rot_en     = 1'b1;
        iter_valid = 1'b1;
        tick();
        iter = 16'd6;
        tick();
        check("pre_rst_offset", 32'(frame_offset), 32'd8);
        check("pre_rst_valid", 32'(valid), 32'd1);
        iter_valid = 1'b0;
        iter_sof   = 1'b0;
        rot_en     = 1'b0;
        areset     = 1'b1;
        tick();
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_offset", 32'(frame_offset), 32'd0);
        areset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("post_rst_no_stale", 32'(valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
